ifetch_queue: RTL and testbench
===============================

IFETCH_QUEUE -- requirements
Module: ifetch_queue

Interface
REQ-001 Parameter DEPTH, default 4, sets the queue entry count (power of two, 2..8).
REQ-002 Parameter RESET_PC, default 32'h0, is the first fetch address after reset.
REQ-003 clk_i  input  1  is the single clock; all state updates on its rising edge.
REQ-004 rst_i  input  1  is an asynchronous, active-low reset.
REQ-005 start_i  input  1  is the fetch enable; new memory requests are issued only while it is high.
REQ-006 redirect_i  input  1  is a branch/jump redirect pulse from the decode/ALU stages.
REQ-007 redirect_pc_i  input  32  is the redirect target; bits [1:0] are ignored and forced to 0.
REQ-008 mem_req_o  output  1  is the instruction-memory request.
REQ-009 mem_addr_o  output  32  is the word-aligned request address.
REQ-010 mem_ack_i  input  1  is the memory acknowledge; mem_data_i is valid in the same cycle.
REQ-011 mem_data_i  input  32  is the returned instruction word.
REQ-012 inst_valid_o  output  1  indicates the queue head is valid.
REQ-013 inst_o  output  32  is the head instruction.
REQ-014 pc_o  output  32  is the head instruction's address.
REQ-015 inst_ready_i  input  1  is consumer ready; a pop occurs when inst_valid_o and inst_ready_i are both high.
REQ-016 count_o  output  4  is the number of valid queue entries.

Function
REQ-017 Request protocol: one outstanding request at most; once mem_req_o rises, mem_req_o and mem_addr_o SHALL hold stable until the cycle mem_ack_i is high.
REQ-018 A new request SHALL be issued only when start_i=1, state is FETCH, no request is outstanding, and count_o < DEPTH.
REQ-019 A request MAY be issued in the cycle after an ack; back-to-back acks yield one word per two cycles minimum.
REQ-020 On an ack in FETCH, {mem_addr_o, mem_data_i} SHALL be pushed; fetch_pc SHALL advance by 4 (mod 2^32, wrapping 32'hFFFFFFFC to 0).
REQ-021 Latency: an ack in cycle N SHALL produce inst_valid_o=1 with that entry at the head in cycle N+1 if the queue was empty.
REQ-022 The queue SHALL be FIFO-ordered; pointers SHALL wrap modulo DEPTH; a push and a pop in the same cycle leave count_o unchanged.
REQ-023 Overflow SHALL be impossible by construction (REQ-018); underflow SHALL be impossible because a pop requires inst_valid_o.
REQ-024 States: IDLE (start_i low, nothing outstanding), FETCH, DISCARD.
REQ-025 IDLE->FETCH when start_i=1; FETCH->IDLE when start_i=0 and nothing outstanding; an outstanding request completes and is pushed normally.
REQ-026 redirect_i SHALL flush the queue (count_o=0, inst_valid_o=0 next cycle) and load fetch_pc with {redirect_pc_i[31:2],2'b00}.
REQ-027 redirect_i with a request outstanding and no ack SHALL enter DISCARD: the request is held per REQ-017, its ack data is dropped, then the state returns to FETCH (or IDLE if start_i=0).
REQ-028 redirect_i coinciding with mem_ack_i SHALL drop that data; the next request SHALL be to the redirect target.
REQ-029 redirect_i coinciding with a pop SHALL take priority; the popped entry is discarded and not counted.
REQ-030 A second redirect_i while in DISCARD SHALL overwrite the target; the state remains DISCARD.
REQ-031 While in DISCARD, no push SHALL occur; inst_valid_o SHALL remain 0.

Reset
REQ-032 On rst_i=0, all outputs SHALL be cleared immediately: mem_req_o=0, mem_addr_o=RESET_PC, inst_valid_o=0, inst_o=0, pc_o=0, count_o=0; fetch_pc=RESET_PC; state IDLE.
REQ-033 Reset mid-request SHALL abandon the request without waiting for an ack; an ack arriving during or after reset release with nothing outstanding SHALL be ignored.

Verification
REQ-034 Reset, start_i=1, ack one cycle after each request, inst_ready_i=1 -> requests to 0x0, 0x4, 0x8; pc_o=0x0 valid the cycle after the first ack.
REQ-035 inst_ready_i=0 with immediate acks -> count_o reaches 4 and mem_req_o stays low; one pop -> request to 0x10 next cycle and count_o=3.
REQ-036 Request to 0x8 outstanding, redirect_i with redirect_pc_i=0x100, ack 3 cycles later -> mem_addr_o stays 0x8 until the ack, data dropped, next request 0x100, count_o=0.
REQ-037 redirect_i to 0x103 in the same cycle as an ack and a pop -> no push, pop discarded, next request 0x100.
REQ-038 fetch_pc=0xFFFFFFFC acked -> next request 0x0.
REQ-039 rst_i low for one cycle mid-request -> all outputs at reset values; after release with start_i=1 -> request to RESET_PC.

Source files
------------

// File: rtl/ifetch_queue.sv
// Instruction fetch unit: issues single-outstanding word requests to instruction memory
// and buffers returned words with their addresses in a small FIFO for decode.
module ifetch_queue #(
   parameter int unsigned DEPTH    = 4,
   parameter logic [31:0] RESET_PC = 32'h0
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        start_i,
   input  logic        redirect_i,
   input  logic [31:0] redirect_pc_i,
   output logic        mem_req_o,
   output logic [31:0] mem_addr_o,
   input  logic        mem_ack_i,
   input  logic [31:0] mem_data_i,
   output logic        inst_valid_o,
   output logic [31:0] inst_o,
   output logic [31:0] pc_o,
   input  logic        inst_ready_i,
   output logic [3:0]  count_o
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = 4;
   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

   typedef enum logic [1:0] {IDLE, FETCH, DISCARD} state_t;

   state_t             state_q, state_d;
   logic [31:0]        q_inst [DEPTH];
   logic [31:0]        q_pc   [DEPTH];
   logic [PTR_W-1:0]   rd_ptr, wr_ptr, rd_ptr_d, wr_ptr_d;
   logic [31:0]        fetch_pc, fetch_pc_d, mem_addr_d;
   logic [31:0]        inst_d, pc_d;
   logic [CNT_W-1:0]   count_d;
   logic               mem_req_d, valid_d;
   logic               ack, push, pop;

   // Next-state, queue bookkeeping and request generation
   always_comb begin
      state_d    = state_q;
      fetch_pc_d = fetch_pc;
      mem_req_d  = mem_req_o;
      mem_addr_d = mem_addr_o;
      rd_ptr_d   = rd_ptr;
      wr_ptr_d   = wr_ptr;
      count_d    = count_o;
      ack        = mem_req_o && mem_ack_i;
      pop        = inst_valid_o && inst_ready_i;
      push       = ack && (state_q == FETCH) && !redirect_i;

      // A redirect wins over any push or pop in the same cycle
      if (redirect_i) begin
         rd_ptr_d   = '0;
         wr_ptr_d   = '0;
         count_d    = '0;
         fetch_pc_d = redirect_pc_i & ~32'd3;
      end else begin
         rd_ptr_d = rd_ptr + PTR_W'(pop);
         wr_ptr_d = wr_ptr + PTR_W'(push);
         count_d  = count_o + CNT_W'(push) - CNT_W'(pop);
         if (push) begin
            fetch_pc_d = fetch_pc + 32'd4;
         end
      end

      case (state_q)
         IDLE: begin
            if (start_i) state_d = FETCH;
         end
         FETCH: begin
            if (redirect_i && mem_req_o && !mem_ack_i) begin
               state_d = DISCARD;
            end else if (!start_i && (!mem_req_o || mem_ack_i)) begin
               state_d = IDLE;
            end
         end
         DISCARD: begin
            if (ack) state_d = start_i ? FETCH : IDLE;
         end
         default: state_d = IDLE;
      endcase

      if (ack) begin
         mem_req_d = 1'b0;
      end else if (!mem_req_o && start_i && (state_q == FETCH) && !redirect_i
                   && (count_d < DEPTH_C)) begin
         mem_req_d  = 1'b1;
         mem_addr_d = fetch_pc;
      end

      // Bypass the incoming word when it becomes the new head
      if (push && (wr_ptr == rd_ptr_d)) begin
         inst_d = mem_data_i;
         pc_d   = mem_addr_o;
      end else begin
         inst_d = q_inst[rd_ptr_d];
         pc_d   = q_pc[rd_ptr_d];
      end
      valid_d = (count_d != '0);
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q      <= IDLE;
         fetch_pc     <= RESET_PC;
         mem_req_o    <= 1'b0;
         mem_addr_o   <= RESET_PC;
         rd_ptr       <= '0;
         wr_ptr       <= '0;
         count_o      <= '0;
         inst_valid_o <= 1'b0;
         inst_o       <= '0;
         pc_o         <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            q_inst[i] <= '0;
            q_pc[i]   <= '0;
         end
      end else begin
         state_q      <= state_d;
         fetch_pc     <= fetch_pc_d;
         mem_req_o    <= mem_req_d;
         mem_addr_o   <= mem_addr_d;
         rd_ptr       <= rd_ptr_d;
         wr_ptr       <= wr_ptr_d;
         count_o      <= count_d;
         inst_valid_o <= valid_d;
         inst_o       <= inst_d;
         pc_o         <= pc_d;
         if (push) begin
            q_inst[wr_ptr] <= mem_data_i;
            q_pc[wr_ptr]   <= mem_addr_o;
         end
      end
   end

endmodule

// File: tb/tb_ifetch_queue.sv
// Directed bench for ifetch_queue: per-cycle vector table plus hand sequences for
// address wrap-around and reset in the middle of a request.
module tb_ifetch_queue;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start, redirect, mem_req, mem_ack, inst_valid, inst_ready;
   logic [31:0] redirect_pc, mem_addr, mem_data, inst, pc;
   logic [3:0]  count;

   int n_vec  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   ifetch_queue #(.DEPTH(4), .RESET_PC(32'h0)) dut (
      .clk_i         (clk),
      .rst_i         (rst_n),
      .start_i       (start),
      .redirect_i    (redirect),
      .redirect_pc_i (redirect_pc),
      .mem_req_o     (mem_req),
      .mem_addr_o    (mem_addr),
      .mem_ack_i     (mem_ack),
      .mem_data_i    (mem_data),
      .inst_valid_o  (inst_valid),
      .inst_o        (inst),
      .pc_o          (pc),
      .inst_ready_i  (inst_ready),
      .count_o       (count)
   );

   function automatic logic [31:0] inst_of(input logic [31:0] a);
      return a ^ 32'hDEAD_BEEF;
   endfunction

   // Instruction memory contents are a fixed function of the address
   assign mem_data = inst_of(mem_addr);

   typedef struct {
      logic        start, redir;
      logic [31:0] rpc;
      logic        ack, ready;
      logic        e_req;
      logic [31:0] e_addr;
      logic        e_valid;
      logic [31:0] e_pc;
      logic [3:0]  e_cnt;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(input logic s, input logic r, input logic [31:0] rpc,
                               input logic a, input logic rd, input logic e_req,
                               input logic [31:0] e_addr, input logic e_valid,
                               input logic [31:0] e_pc, input logic [3:0] e_cnt);
      vec_t v;
      v.start = s;  v.redir = r;  v.rpc = rpc;  v.ack = a;  v.ready = rd;
      v.e_req = e_req;  v.e_addr = e_addr;  v.e_valid = e_valid;
      v.e_pc = e_pc;  v.e_cnt = e_cnt;
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic wait_req(input string name);
      int n = 0;
      while (!mem_req && n < 8) begin
         @(negedge clk);
         n++;
      end
      check({name, " req"}, 32'(mem_req), 32'd1);
   endtask

   initial begin
      // start, redir, rpc, ack, ready | req, addr, valid, pc, count
      vecs.push_back(mk(1,0,0,0,1, 0,0,0,0,0));
      vecs.push_back(mk(1,0,0,0,1, 0,0,0,0,0));
      vecs.push_back(mk(1,0,0,0,1, 1,32'h0,0,0,0));
      vecs.push_back(mk(1,0,0,1,1, 1,32'h0,0,0,0));
      vecs.push_back(mk(1,0,0,0,1, 0,0,1,32'h0,1));
      vecs.push_back(mk(1,0,0,0,1, 1,32'h4,0,0,0));
      vecs.push_back(mk(1,0,0,1,1, 1,32'h4,0,0,0));
      vecs.push_back(mk(1,0,0,0,1, 0,0,1,32'h4,1));
      vecs.push_back(mk(1,0,0,0,1, 1,32'h8,0,0,0));
      vecs.push_back(mk(1,0,0,1,1, 1,32'h8,0,0,0));
      vecs.push_back(mk(0,0,0,0,1, 0,0,1,32'h8,1));
      vecs.push_back(mk(1,0,0,0,0, 0,0,0,0,0));
      vecs.push_back(mk(1,0,0,0,0, 0,0,0,0,0));
      vecs.push_back(mk(1,0,0,1,0, 1,32'hC,0,0,0));
      vecs.push_back(mk(1,0,0,0,0, 0,0,1,32'hC,1));
      vecs.push_back(mk(1,0,0,1,0, 1,32'h10,1,32'hC,1));
      vecs.push_back(mk(1,0,0,0,0, 0,0,1,32'hC,2));
      vecs.push_back(mk(1,0,0,1,0, 1,32'h14,1,32'hC,2));
      vecs.push_back(mk(1,0,0,0,0, 0,0,1,32'hC,3));
      vecs.push_back(mk(1,0,0,1,0, 1,32'h18,1,32'hC,3));
      vecs.push_back(mk(1,0,0,0,0, 0,0,1,32'hC,4));
      vecs.push_back(mk(1,0,0,0,1, 0,0,1,32'hC,4));
      vecs.push_back(mk(1,0,0,1,0, 1,32'h1C,1,32'h10,3));
      vecs.push_back(mk(1,1,32'h100,0,0, 0,0,1,32'h10,4));
      vecs.push_back(mk(1,0,0,0,0, 0,0,0,0,0));
      vecs.push_back(mk(1,1,32'h200,0,0, 1,32'h100,0,0,0));
      vecs.push_back(mk(1,0,0,0,0, 1,32'h100,0,0,0));
      vecs.push_back(mk(1,1,32'h300,0,0, 1,32'h100,0,0,0));
      vecs.push_back(mk(1,0,0,1,0, 1,32'h100,0,0,0));
      vecs.push_back(mk(1,0,0,0,0, 0,0,0,0,0));
      vecs.push_back(mk(1,0,0,1,0, 1,32'h300,0,0,0));
      vecs.push_back(mk(1,0,0,0,0, 0,0,1,32'h300,1));
      vecs.push_back(mk(1,1,32'h103,1,1, 1,32'h304,1,32'h300,1));
      vecs.push_back(mk(1,0,0,0,0, 0,0,0,0,0));
      vecs.push_back(mk(1,0,0,1,1, 1,32'h100,0,0,0));

      rst_n = 1'b0;  start = 1'b0;  redirect = 1'b0;  redirect_pc = '0;
      mem_ack = 1'b0;  inst_ready = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check("reset req",   32'(mem_req), 32'd0);
      check("reset addr",  mem_addr, 32'h0);
      check("reset valid", 32'(inst_valid), 32'd0);
      check("reset count", 32'(count), 32'd0);
      rst_n = 1'b1;

      foreach (vecs[i]) begin
         vec_t v;
         v = vecs[i];
         @(negedge clk);
         check($sformatf("v%0d req", i), 32'(mem_req), 32'(v.e_req));
         if (v.e_req) check($sformatf("v%0d addr", i), mem_addr, v.e_addr);
         check($sformatf("v%0d valid", i), 32'(inst_valid), 32'(v.e_valid));
         if (v.e_valid) begin
            check($sformatf("v%0d pc", i), pc, v.e_pc);
            check($sformatf("v%0d inst", i), inst, inst_of(v.e_pc));
         end
         check($sformatf("v%0d count", i), 32'(count), 32'(v.e_cnt));
         start = v.start;  redirect = v.redir;  redirect_pc = v.rpc;
         mem_ack = v.ack;  inst_ready = v.ready;
      end

      // Redirect to the top word (low bits ignored) and wrap to address 0
      @(negedge clk);
      check("wrap pre valid", 32'(inst_valid), 32'd1);
      check("wrap pre pc", pc, 32'h100);
      mem_ack = 1'b0;  redirect = 1'b1;  redirect_pc = 32'hFFFF_FFFF;  inst_ready = 1'b1;
      @(negedge clk);
      redirect = 1'b0;  inst_ready = 1'b0;
      check("wrap flush count", 32'(count), 32'd0);
      wait_req("wrap top");
      check("wrap top addr", mem_addr, 32'hFFFF_FFFC);
      mem_ack = 1'b1;
      @(negedge clk);
      mem_ack = 1'b0;
      check("wrap head pc", pc, 32'hFFFF_FFFC);
      check("wrap head inst", inst, inst_of(32'hFFFF_FFFC));
      wait_req("wrap zero");
      check("wrap zero addr", mem_addr, 32'h0);
      mem_ack = 1'b1;
      @(negedge clk);
      mem_ack = 1'b0;
      check("pre reset count", 32'(count), 32'd2);
      wait_req("pre reset");
      check("pre reset addr", mem_addr, 32'h4);

      // Asynchronous reset while a request is outstanding; stray acks ignored
      rst_n = 1'b0;  mem_ack = 1'b1;
      #1;
      check("mid reset req",   32'(mem_req), 32'd0);
      check("mid reset addr",  mem_addr, 32'h0);
      check("mid reset valid", 32'(inst_valid), 32'd0);
      check("mid reset inst",  inst, 32'h0);
      check("mid reset pc",    pc, 32'h0);
      check("mid reset count", 32'(count), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      mem_ack = 1'b0;
      check("post reset valid", 32'(inst_valid), 32'd0);
      check("post reset count", 32'(count), 32'd0);
      wait_req("post reset");
      check("post reset addr", mem_addr, 32'h0);
      mem_ack = 1'b1;
      @(negedge clk);
      mem_ack = 1'b0;
      check("post reset head pc", pc, 32'h0);
      check("post reset head valid", 32'(inst_valid), 32'd1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
